uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; SHALL be a power of two, 2 to 256.
REQ-002 Parameter CNT_W, default $clog2(DEPTH)+1, width of o_count.
REQ-003 clk  input  1  system clock (PLL output domain); all logic SHALL be on its rising edge.
REQ-004 rst_n  input  1  reset; synchronous and active-low.
REQ-005 i_data  input  8  byte to enqueue.
REQ-006 i_wr_en  input  1  enqueue request; one byte per cycle while high.
REQ-007 i_clr_ovf  input  1  clears o_overflow.
REQ-008 o_full  output  1  high when count == DEPTH.
REQ-009 o_empty  output  1  high when count == 0.
REQ-010 o_count  output  CNT_W  bytes currently stored.
REQ-011 o_overflow  output  1  sticky flag; a write was dropped.
REQ-012 o_tx_data  output  8  byte to the UART transmitter's i_data.
REQ-013 o_tx_start  output  1  single-cycle start pulse to the transmitter's i_tx_start.
REQ-014 i_tx_busy  input  1  transmitter's o_tx_busy; rises the cycle after start is sampled and stays high through the stop bit.

Function
REQ-015 Storage SHALL be a DEPTH x 8 array with read/write pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH.
REQ-016 Accepted write (i_wr_en & !o_full) SHALL store i_data at wr_ptr, then increment wr_ptr; visible in o_count on the next cycle.
REQ-017 Write while o_full SHALL be dropped (no pointer or count change); o_overflow set on the next edge.
REQ-018 o_overflow SHALL stay set until i_clr_ovf; a drop and i_clr_ovf in the same cycle leave it set.
REQ-019 FSM states: IDLE, LAUNCH, GUARD, DRAIN.
REQ-020 IDLE: when !o_empty and !i_tx_busy, on the edge: o_tx_data <= mem[rd_ptr], o_tx_start <= 1, rd_ptr increments, count decrements, go to LAUNCH; otherwise stay.
REQ-021 LAUNCH: o_tx_start high for this cycle only; go to GUARD unconditionally.
REQ-022 GUARD: one cycle for i_tx_busy to rise; go to DRAIN unconditionally.
REQ-023 DRAIN: stay while i_tx_busy high; go to IDLE on the first cycle it is low.
REQ-024 o_tx_data SHALL hold the launched byte until the next launch.
REQ-025 Latency: empty FIFO, IDLE, busy low, write sampled at edge N gives o_tx_start high after edge N+1.
REQ-026 Write and pop on the same edge SHALL leave o_count unchanged and both pointers advanced.
REQ-027 Write on the same edge a pop frees the last full slot SHALL be dropped, because o_full is evaluated before the pop.
REQ-028 o_full and o_empty SHALL be derived from the registered count, never both high.
REQ-029 Bytes SHALL leave in write order; at most one launch per 3 + busy-duration cycles.

Reset
REQ-030 With rst_n low at a rising edge: pointers 0, count 0, state IDLE, o_tx_start 0, o_tx_data 8'h00, o_overflow 0, o_empty 1, o_full 0.
REQ-031 Reset mid-transfer SHALL discard all stored bytes; FSM returns to IDLE and ignores i_tx_busy until the next launch condition.
REQ-032 Memory contents need no reset.

Verification
REQ-033 Single byte: reset, write 8'h48 at edge N with busy low -> o_tx_start high after N+1 only, o_tx_data=8'h48, o_count back to 0.
REQ-034 Stream: write "Hello, World!\n" (14 bytes) back-to-back into DEPTH=16, transmitter model with 10-bit-time busy -> 14 start pulses in order, none while busy high, o_overflow stays 0.
REQ-035 Overflow: busy held high, write 17 bytes -> o_full after 16th, 17th dropped, o_overflow=1; i_clr_ovf pulse -> 0; release busy -> 16 bytes out in order.
REQ-036 Wrap: DEPTH=4, write and drain 10 bytes in groups of 3 -> pointers wrap, output order exact, o_count never exceeds 4.
REQ-037 Simultaneous: count=2 and a launch edge with i_wr_en -> o_count stays 2 next cycle.
REQ-038 Reset mid-operation: count=5, DRAIN, assert rst_n low for one edge -> all REQ-030 values; no o_tx_start until a new write.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of a UART transmitter. It launches one byte per transmitter
// busy period and exposes fill level, full/empty and a sticky overflow flag.
module uart_tx_fifo #(
   parameter int DEPTH = 16,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       i_data,
   input  logic             i_wr_en,
   input  logic             i_clr_ovf,
   output logic             o_full,
   output logic             o_empty,
   output logic [CNT_W-1:0] o_count,
   output logic             o_overflow,
   output logic [7:0]       o_tx_data,
   output logic             o_tx_start,
   input  logic             i_tx_busy,
   output logic [1:0]       o_dbg_state
);

   localparam int PTR_W = $clog2(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_GUARD, S_DRAIN} state_t;

   // Handshake: a byte leaves when the FSM is in IDLE, the FIFO holds data and
   // the transmitter reports not busy; o_tx_start pulses for exactly one cycle
   // with o_tx_data already valid, and o_tx_data holds until the next launch.
   state_t           r_state;
   state_t           w_next_state;
   logic [7:0]       r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             r_overflow;
   logic [7:0]       r_tx_data;
   logic             r_tx_start;
   logic             w_wr;
   logic             w_pop;

   assign o_full      = (r_count == CNT_W'(DEPTH));
   assign o_empty     = (r_count == '0);
   assign o_count     = r_count;
   assign o_overflow  = r_overflow;
   assign o_tx_data   = r_tx_data;
   assign o_tx_start  = r_tx_start;
   assign o_dbg_state = r_state;

   // Full is judged on the registered count, so a pop never makes room for a
   // write on the same edge.
   assign w_wr  = i_wr_en & ~o_full;
   assign w_pop = (r_state == S_IDLE) & ~o_empty & ~i_tx_busy;

   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         r_tx_data  <= 8'h00;
         r_tx_start <= 1'b0;
      end else begin
         r_tx_start <= w_pop;
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
            r_tx_data <= r_mem[r_rd_ptr];
         end
         case ({w_wr, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
         // A drop wins over a clear in the same cycle.
         if (i_wr_en && o_full) begin
            r_overflow <= 1'b1;
         end else if (i_clr_ovf) begin
            r_overflow <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:   if (w_pop) w_next_state = S_LAUNCH;
         S_LAUNCH: w_next_state = S_GUARD;
         S_GUARD:  w_next_state = S_DRAIN;
         S_DRAIN:  if (!i_tx_busy) w_next_state = S_IDLE;
         default:  w_next_state = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised bench for uart_tx_fifo: a queue-based reference model predicts
// every output each cycle while a simple transmitter model drives i_tx_busy.
module tb_uart_tx_fifo;

   localparam int DEPTH = 16;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [7:0]       i_data;
   logic             i_wr_en;
   logic             i_clr_ovf;
   logic             i_tx_busy = 1'b0;
   logic             o_full;
   logic             o_empty;
   logic [CNT_W-1:0] o_count;
   logic             o_overflow;
   logic [7:0]       o_tx_data;
   logic             o_tx_start;
   logic [1:0]       o_dbg_state;

   int n_tests = 0;
   int n_fail  = 0;

   uart_tx_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_data     (i_data),
      .i_wr_en    (i_wr_en),
      .i_clr_ovf  (i_clr_ovf),
      .o_full     (o_full),
      .o_empty    (o_empty),
      .o_count    (o_count),
      .o_overflow (o_overflow),
      .o_tx_data  (o_tx_data),
      .o_tx_start (o_tx_start),
      .i_tx_busy  (i_tx_busy),
      .o_dbg_state(o_dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // transmitter model: busy rises the cycle after start is sampled
   int busy_len   = 10;
   int tx_cnt     = 0;
   bit force_busy = 1'b0;
   bit rand_busy  = 1'b0;
   int n_starts   = 0;

   always @(posedge clk) begin
      if (o_tx_start) begin
         n_starts++;
         tx_cnt = rand_busy ? $urandom_range(1, 6) : busy_len;
      end else if (tx_cnt > 0) begin
         tx_cnt--;
      end
   end

   always @(negedge clk) i_tx_busy = force_busy || (tx_cnt > 0);

   // reference model: FIFO as a queue, launch spacing as a gap/wait rule
   logic [7:0] exp_q[$];
   bit         m_ovf   = 1'b0;
   bit         m_start = 1'b0;
   logic [7:0] m_data  = 8'h00;
   int         m_gap   = 0;
   bit         m_wait  = 1'b0;
   bit         chk_en  = 1'b0;

   always @(posedge clk) begin
      bit full;
      bit pop;
      if (!rst_n) begin
         exp_q.delete();
         m_ovf = 0; m_start = 0; m_data = 8'h00; m_gap = 0; m_wait = 0;
      end else begin
         full = (exp_q.size() == DEPTH);
         pop  = (m_gap == 0) && !m_wait && (exp_q.size() != 0) && !i_tx_busy;
         m_start = pop;
         if (pop) m_data = exp_q.pop_front();
         if (i_wr_en && !full) exp_q.push_back(i_data);
         if (i_wr_en && full) m_ovf = 1;
         else if (i_clr_ovf)  m_ovf = 0;
         // after a launch: two fixed cycles, then wait for the first idle busy sample
         if (pop) begin
            m_gap = 2; m_wait = 1;
         end else if (m_gap > 0) begin
            m_gap--;
         end else if (m_wait && !i_tx_busy) begin
            m_wait = 0;
         end
      end
   end

   // scoreboard: compare every output away from the active edge
   always @(negedge clk) begin
      if (chk_en) begin
         check_eq("count",    32'(o_count), 32'(exp_q.size()));
         check_eq("full",     32'(o_full), 32'(exp_q.size() == DEPTH));
         check_eq("empty",    32'(o_empty), 32'(exp_q.size() == 0));
         check_eq("overflow", 32'(o_overflow), 32'(m_ovf));
         check_eq("tx_start", 32'(o_tx_start), 32'(m_start));
         check_eq("tx_data",  32'(o_tx_data), 32'(m_data));
      end
   end

   // driver tasks
   task automatic write_byte(input logic [7:0] d);
      i_wr_en = 1'b1;
      i_data  = d;
      @(negedge clk);
      i_wr_en = 1'b0;
   endtask

   task automatic wait_drain(input int max_cycles);
      int k;
      k = 0;
      while ((exp_q.size() != 0 || m_gap != 0 || m_wait || tx_cnt != 0) && k < max_cycles) begin
         @(negedge clk);
         k++;
      end
      if (k >= max_cycles) check_eq("drain_timeout", 32'(k), 32'(0));
   endtask

   // directed scenarios then random traffic
   initial begin
      string hello;
      int    s0;
      hello     = "Hello, World!\n";
      rst_n     = 1'b0;
      i_wr_en   = 1'b0;
      i_data    = 8'h00;
      i_clr_ovf = 1'b0;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      check_eq("rst_empty", 32'(o_empty), 32'd1);
      check_eq("rst_count", 32'(o_count), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // single byte latency
      write_byte(8'h48);
      check_eq("single_no_early_start", 32'(o_tx_start), 32'd0);
      @(negedge clk);
      check_eq("single_start", 32'(o_tx_start), 32'd1);
      check_eq("single_data",  32'(o_tx_data), 32'h48);
      check_eq("single_count", 32'(o_count), 32'd0);
      wait_drain(200);

      // back-to-back stream with a 10-cycle busy transmitter
      s0 = n_starts;
      busy_len = 10;
      for (int i = 0; i < hello.len(); i++) write_byte(hello[i]);
      wait_drain(1000);
      check_eq("stream_starts", 32'(n_starts - s0), 32'd14);
      check_eq("stream_no_ovf", 32'(o_overflow), 32'd0);

      // overflow with the transmitter held busy
      force_busy = 1'b1;
      repeat (2) @(negedge clk);
      s0 = n_starts;
      for (int i = 0; i < 17; i++) write_byte(8'(8'hA0 + i));
      check_eq("ovf_full", 32'(o_full), 32'd1);
      check_eq("ovf_flag", 32'(o_overflow), 32'd1);
      check_eq("ovf_count", 32'(o_count), 32'd16);
      i_clr_ovf = 1'b1;
      @(negedge clk);
      i_clr_ovf = 1'b0;
      check_eq("ovf_cleared", 32'(o_overflow), 32'd0);
      force_busy = 1'b0;
      busy_len = 3;
      wait_drain(2000);
      check_eq("ovf_drain_starts", 32'(n_starts - s0), 32'd16);

      // random traffic: wraps pointers, hits simultaneous write/pop and full drops
      rand_busy = 1'b1;
      for (int phase = 0; phase < 4; phase++) begin
         int wr_pct;
         wr_pct = (phase % 2 == 0) ? 70 : 20;
         for (int c = 0; c < 250; c++) begin
            i_wr_en   = ($urandom_range(0, 99) < wr_pct);
            i_data    = 8'($urandom);
            i_clr_ovf = ($urandom_range(0, 19) == 0);
            @(negedge clk);
         end
      end
      i_wr_en   = 1'b0;
      i_clr_ovf = 1'b0;
      rand_busy = 1'b0;
      wait_drain(2000);

      // reset while a byte is in flight and five remain queued
      busy_len   = 10;
      force_busy = 1'b1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 6; i++) write_byte(8'(8'h30 + i));
      force_busy = 1'b0;
      repeat (6) @(negedge clk);
      check_eq("mid_count", 32'(o_count), 32'd5);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_eq("mid_rst_count", 32'(o_count), 32'd0);
      check_eq("mid_rst_data",  32'(o_tx_data), 32'h00);
      check_eq("mid_rst_empty", 32'(o_empty), 32'd1);
      s0 = n_starts;
      repeat (30) @(negedge clk);
      check_eq("mid_no_start", 32'(n_starts - s0), 32'd0);
      write_byte(8'h5A);
      wait_drain(200);
      check_eq("post_rst_start", 32'(n_starts - s0), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #600000;
      n_tests++;
      n_fail++;
      $display("FAIL watchdog: simulation did not complete in time");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
